config_bus_master: RTL and testbench
====================================

Name: config_bus_master

Overview:
- Initiator for the per-core configuration bus.
- Accepts single read or write requests from a host-side valid/ready port.
- Drives the config_config_addr, config_config_data, config_read and config_write strobes into a core, and captures read_config_data for reads.
- Returns one response per request, so the host (test harness or global controller) can sequence configuration of a tile.

Parameters:
ADDR_WIDTH, 8, width of the config address bus
DATA_WIDTH, 32, width of the config write-data and read-data buses
READ_LATENCY, 0, cycles from the read strobe cycle until read_config_data is valid; legal range 0..15

Ports:
clk  input  1  clock; all logic is on the rising edge
reset  input  1  synchronous, active-low reset
req_valid  input  1  host request valid
req_ready  output  1  master can accept a request this cycle
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  target config register address
req_data  input  DATA_WIDTH  write data; ignored for reads
resp_valid  output  1  response valid
resp_ready  input  1  host accepts the response
resp_write  output  1  response belongs to a write (1) or a read (0)
resp_data  output  DATA_WIDTH  captured read data; 0 for writes
busy  output  1  high in every state except IDLE
config_config_addr  output  ADDR_WIDTH  address to the core
config_config_data  output  DATA_WIDTH  write data to the core
config_read  output  1  one-cycle read strobe
config_write  output  1  one-cycle write strobe
read_config_data  input  DATA_WIDTH  read data from the core's read mux

Behaviour:
- Reset: when reset is low at a rising edge, all state and outputs clear on that edge.
  - State goes to IDLE.
  - Address, data, resp_data, resp_write, strobes, resp_valid and busy all become 0.
  - req_ready becomes 1 once reset is released.
- Reset mid-transaction: any in-flight request is dropped silently. No strobe and no response is issued after reset.
- States: IDLE, STROBE, WAIT, RESP.
- IDLE:
  - req_ready = 1; req_ready is decoded from state only and never depends on req_valid.
  - When req_valid is high, the request is accepted in this cycle (A).
  - req_write, req_addr and req_data are registered and the state moves to STROBE.
- STROBE (cycle A+1):
  - config_config_addr and config_config_data drive the registered values.
  - Exactly one strobe is high, for exactly this one cycle: config_write for a write, config_read for a read.
  - Write: next state is RESP.
  - Read with READ_LATENCY = 0: read_config_data is sampled at the end of this cycle, then next state is RESP.
  - Read with READ_LATENCY > 0: load the wait counter with READ_LATENCY and go to WAIT.
- WAIT:
  - Strobes are low; address is held stable.
  - The counter decrements every cycle.
  - In the cycle where the counter equals 1, read_config_data is sampled and the state moves to RESP.
  - The sample point is therefore the end of cycle A+1+READ_LATENCY.
- RESP:
  - resp_valid = 1; resp_data and resp_write are held stable until the cycle in which resp_ready is high.
  - The state returns to IDLE on the following edge.
  - For writes, resp_data = 0.
- Latency from accept cycle A to the first resp_valid cycle:
  - Write: resp_valid first high in cycle A+2.
  - Read: resp_valid first high in cycle A+2+READ_LATENCY.
- Back-to-back: if the response handshakes in cycle R, the next request can be accepted in cycle R+1. There is no overlap of transactions.
- Bus hold: config_config_addr and config_config_data keep their last driven values between transactions; they are not zeroed.
- Strobe exclusivity: config_read and config_write are never high together and are never high outside STROBE.
- Host-side errors:
  - req_valid while not in IDLE is ignored, and the request fields are not sampled.
  - resp_ready outside RESP has no effect.
- Counter width: 4 bits. READ_LATENCY values outside 0..15 are a parameter error, flagged with an elaboration-time check.

Test Plan:
- Reset: hold reset low for 3 cycles while req_valid=1 -> no strobes issued, resp_valid=0, busy=0; after release, req_ready=1.
- Write: req addr=0x01, data=0xDEADBEEF, write=1, accepted in cycle 5 -> config_write=1 only in cycle 6 with addr 0x01 and data 0xDEADBEEF; resp_valid=1 in cycle 7 with resp_write=1, resp_data=0.
- Read, READ_LATENCY=0: core model returns 0x12345678 combinationally for addr 0x00; read accepted in cycle 5 -> config_read=1 in cycle 6; resp_valid in cycle 7 with resp_data=0x12345678, resp_write=0.
- Read, READ_LATENCY=3: data appears only 3 cycles after the strobe; read accepted in cycle 5 -> strobe in cycle 6, sample at end of cycle 9, resp_valid in cycle 10; captured data is the delayed value, not the value present earlier.
- Backpressure and back-to-back: hold resp_ready=0 for 4 cycles -> resp_valid and resp_data stay stable, req_ready=0, a second req_valid is ignored; release resp_ready -> the second request is accepted the cycle after the handshake.
- Reset mid-read: with READ_LATENCY=3, assert reset during WAIT -> next edge gives IDLE with all outputs 0, and no resp_valid ever appears for the dropped read.

Source files
------------

// File: rtl/config_bus_master_if.sv
// Host-side request/response channel of the configuration bus master.
// Both channels use valid/ready: a transfer occurs on a rising edge where valid and ready are both high.
interface config_bus_master_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_data;
   logic                  resp_valid;
   logic                  resp_ready;
   logic                  resp_write;
   logic [DATA_WIDTH-1:0] resp_data;

   // Host side: issues requests and consumes responses.
   modport master (
      output req_valid, req_write, req_addr, req_data, resp_ready,
      input  req_ready, resp_valid, resp_write, resp_data
   );

   // Configuration bus master side.
   modport slave (
      input  req_valid, req_write, req_addr, req_data, resp_ready,
      output req_ready, resp_valid, resp_write, resp_data
   );
endinterface

// File: rtl/config_bus_master.sv
// Single-outstanding initiator for the per-core configuration bus: one strobe per host
// request, optional fixed read latency, one response per request.
module config_bus_master #(
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   config_bus_master_if.slave    host,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] config_config_addr,
   output logic [DATA_WIDTH-1:0] config_config_data,
   output logic                  config_read,
   output logic                  config_write,
   input  logic [DATA_WIDTH-1:0] read_config_data,
   output logic [1:0]            dbg_state
);

   if (READ_LATENCY < 0 || READ_LATENCY > 15) begin : g_bad_latency
      $error("config_bus_master: READ_LATENCY must be within 0..15");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STROBE = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t     state;
   logic       wr_q;
   logic [3:0] cnt;

   assign host.req_ready = (state == IDLE);
   assign busy           = (state != IDLE);
   assign dbg_state      = state;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state              <= IDLE;
         wr_q               <= 1'b0;
         cnt                <= 4'd0;
         config_config_addr <= '0;
         config_config_data <= '0;
         config_read        <= 1'b0;
         config_write       <= 1'b0;
         host.resp_valid    <= 1'b0;
         host.resp_write    <= 1'b0;
         host.resp_data     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (host.req_valid) begin
                  wr_q               <= host.req_write;
                  config_config_addr <= host.req_addr;
                  // Write data is don't-care for reads, so the data bus keeps its last write value.
                  if (host.req_write) config_config_data <= host.req_data;
                  config_write       <= host.req_write;
                  config_read        <= ~host.req_write;
                  state              <= STROBE;
               end
            end
            STROBE: begin
               config_read  <= 1'b0;
               config_write <= 1'b0;
               if (wr_q) begin
                  host.resp_valid <= 1'b1;
                  host.resp_write <= 1'b1;
                  host.resp_data  <= '0;
                  state           <= RESP;
               end else if (READ_LATENCY == 0) begin
                  host.resp_valid <= 1'b1;
                  host.resp_write <= 1'b0;
                  host.resp_data  <= read_config_data;
                  state           <= RESP;
               end else begin
                  cnt   <= 4'(READ_LATENCY);
                  state <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               // Count of 1 marks the cycle A+1+READ_LATENCY, where read data is valid.
               if (cnt == 4'd1) begin
                  host.resp_valid <= 1'b1;
                  host.resp_write <= 1'b0;
                  host.resp_data  <= read_config_data;
                  state           <= RESP;
               end
            end
            RESP: begin
               if (host.resp_ready) begin
                  host.resp_valid <= 1'b0;
                  state           <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_config_bus_master.sv
// Directed bench: one master with READ_LATENCY=0 and one with READ_LATENCY=3, each
// driving a small core model; every step checks outputs against hand-computed values.
module tb_config_bus_master;

   logic        clk = 1'b0;
   logic        rst0 = 1'b0;
   logic        rst3 = 1'b0;
   logic        busy0, busy3;
   logic [7:0]  addr0, addr3;
   logic [31:0] wdata0, wdata3;
   logic        rd0, wr0, rd3, wr3;
   logic [31:0] rdata0, rdata3;
   logic [1:0]  st0, st3;
   logic [1:0]  dly;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   config_bus_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) h0 ();
   config_bus_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) h3 ();

   config_bus_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(0)) dut0 (
      .clk(clk), .reset(rst0), .host(h0), .busy(busy0),
      .config_config_addr(addr0), .config_config_data(wdata0),
      .config_read(rd0), .config_write(wr0),
      .read_config_data(rdata0), .dbg_state(st0)
   );

   config_bus_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(3)) dut3 (
      .clk(clk), .reset(rst3), .host(h3), .busy(busy3),
      .config_config_addr(addr3), .config_config_data(wdata3),
      .config_read(rd3), .config_write(wr3),
      .read_config_data(rdata3), .dbg_state(st3)
   );

   // Zero-latency core: combinational read mux.
   assign rdata0 = (addr0 == 8'h00) ? 32'h1234_5678 : (32'hA5A5_0000 | {24'h0, addr0});

   // Three-cycle core: valid data only in the third cycle after the strobe cycle.
   always @(posedge clk) begin
      if (rd3) dly <= 2'd1;
      else if (dly == 2'd1 || dly == 2'd2) dly <= dly + 2'd1;
      else dly <= 2'd0;
   end
   assign rdata3 = (dly == 2'd3) ? 32'hCAFE_F00D : 32'hBAD0_BAD0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      dly = 2'd0;
      h0.req_valid = 1'b1; h0.req_write = 1'b1; h0.req_addr = 8'h44; h0.req_data = 32'h5555_5555;
      h0.resp_ready = 1'b1;
      h3.req_valid = 1'b1; h3.req_write = 1'b0; h3.req_addr = 8'h44; h3.req_data = 32'h0;
      h3.resp_ready = 1'b1;

      // Reset held for 3 cycles with requests pending.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_wr0", {31'h0, wr0}, 32'h0);
         chk("rst_rd0", {31'h0, rd0}, 32'h0);
         chk("rst_rv0", {31'h0, h0.resp_valid}, 32'h0);
         chk("rst_busy0", {31'h0, busy0}, 32'h0);
         chk("rst_rd3", {31'h0, rd3}, 32'h0);
         chk("rst_busy3", {31'h0, busy3}, 32'h0);
      end
      chk("rst_addr0", {24'h0, addr0}, 32'h0);
      chk("rst_data0", wdata0, 32'h0);
      chk("rst_state0", {30'h0, st0}, 32'h0);
      h0.req_valid = 1'b0; h3.req_valid = 1'b0;
      rst0 = 1'b1; rst3 = 1'b1;
      tick();
      chk("rel_ready0", {31'h0, h0.req_ready}, 32'h1);
      chk("rel_ready3", {31'h0, h3.req_ready}, 32'h1);
      chk("rel_rv0", {31'h0, h0.resp_valid}, 32'h0);

      // Write: accept cycle A, strobe A+1, response A+2.
      h0.req_valid = 1'b1; h0.req_write = 1'b1; h0.req_addr = 8'h01; h0.req_data = 32'hDEAD_BEEF;
      tick();
      h0.req_valid = 1'b0;
      chk("wr_strobe", {31'h0, wr0}, 32'h1);
      chk("wr_nord", {31'h0, rd0}, 32'h0);
      chk("wr_addr", {24'h0, addr0}, 32'h01);
      chk("wr_data", wdata0, 32'hDEAD_BEEF);
      chk("wr_rv_early", {31'h0, h0.resp_valid}, 32'h0);
      chk("wr_busy", {31'h0, busy0}, 32'h1);
      chk("wr_ready", {31'h0, h0.req_ready}, 32'h0);
      tick();
      chk("wr_strobe_off", {31'h0, wr0}, 32'h0);
      chk("wr_rv", {31'h0, h0.resp_valid}, 32'h1);
      chk("wr_rwrite", {31'h0, h0.resp_write}, 32'h1);
      chk("wr_rdata", h0.resp_data, 32'h0);
      tick();
      chk("wr_done_rv", {31'h0, h0.resp_valid}, 32'h0);
      chk("wr_done_ready", {31'h0, h0.req_ready}, 32'h1);
      chk("hold_addr", {24'h0, addr0}, 32'h01);
      chk("hold_data", wdata0, 32'hDEAD_BEEF);

      // Read with zero latency.
      h0.req_valid = 1'b1; h0.req_write = 1'b0; h0.req_addr = 8'h00;
      tick();
      h0.req_valid = 1'b0;
      chk("rd0_strobe", {31'h0, rd0}, 32'h1);
      chk("rd0_nowr", {31'h0, wr0}, 32'h0);
      chk("rd0_rv_early", {31'h0, h0.resp_valid}, 32'h0);
      tick();
      chk("rd0_strobe_off", {31'h0, rd0}, 32'h0);
      chk("rd0_rv", {31'h0, h0.resp_valid}, 32'h1);
      chk("rd0_rdata", h0.resp_data, 32'h1234_5678);
      chk("rd0_rwrite", {31'h0, h0.resp_write}, 32'h0);
      tick();
      chk("rd0_done", {31'h0, h0.req_ready}, 32'h1);

      // Backpressure: read of addr 5, response stalled for 4 cycles while a second request waits.
      h0.req_valid = 1'b1; h0.req_write = 1'b0; h0.req_addr = 8'h05;
      tick();
      h0.req_valid = 1'b0;
      h0.resp_ready = 1'b0;
      tick();
      h0.req_valid = 1'b1; h0.req_write = 1'b1; h0.req_addr = 8'h77; h0.req_data = 32'h0BAD_0BAD;
      for (int k = 0; k < 4; k++) begin
         chk("bp_rv", {31'h0, h0.resp_valid}, 32'h1);
         chk("bp_rdata", h0.resp_data, 32'hA5A5_0005);
         chk("bp_ready", {31'h0, h0.req_ready}, 32'h0);
         chk("bp_nowr", {31'h0, wr0}, 32'h0);
         chk("bp_nord", {31'h0, rd0}, 32'h0);
         if (k == 2) begin
            h0.req_addr = 8'h33; h0.req_data = 32'h1122_3344;
         end
         tick();
      end
      h0.resp_ready = 1'b1;
      chk("bp_rv_hs", {31'h0, h0.resp_valid}, 32'h1);
      tick();
      chk("b2b_ready", {31'h0, h0.req_ready}, 32'h1);
      chk("b2b_rv_off", {31'h0, h0.resp_valid}, 32'h0);
      chk("b2b_no_early_wr", {31'h0, wr0}, 32'h0);
      tick();
      h0.req_valid = 1'b0;
      chk("b2b_strobe", {31'h0, wr0}, 32'h1);
      chk("b2b_addr", {24'h0, addr0}, 32'h33);
      chk("b2b_data", wdata0, 32'h1122_3344);
      tick();
      chk("b2b_rv", {31'h0, h0.resp_valid}, 32'h1);
      chk("b2b_rwrite", {31'h0, h0.resp_write}, 32'h1);
      tick();
      chk("b2b_idle", {30'h0, st0}, 32'h0);

      // Read with latency 3: strobe A+1, sample end of A+4, response A+5.
      h3.req_valid = 1'b1; h3.req_write = 1'b0; h3.req_addr = 8'h10;
      tick();
      h3.req_valid = 1'b0;
      chk("rd3_strobe", {31'h0, rd3}, 32'h1);
      chk("rd3_nowr", {31'h0, wr3}, 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rd3_wait_rv", {31'h0, h3.resp_valid}, 32'h0);
         chk("rd3_wait_strobe", {31'h0, rd3}, 32'h0);
         chk("rd3_wait_addr", {24'h0, addr3}, 32'h10);
         chk("rd3_wait_busy", {31'h0, busy3}, 32'h1);
      end
      tick();
      chk("rd3_rv", {31'h0, h3.resp_valid}, 32'h1);
      chk("rd3_rdata", h3.resp_data, 32'hCAFE_F00D);
      chk("rd3_rwrite", {31'h0, h3.resp_write}, 32'h0);
      tick();
      chk("rd3_done", {31'h0, h3.req_ready}, 32'h1);

      // Reset during WAIT drops the read.
      h3.req_valid = 1'b1; h3.req_write = 1'b0; h3.req_addr = 8'h20;
      tick();
      h3.req_valid = 1'b0;
      chk("mid_strobe", {31'h0, rd3}, 32'h1);
      tick();
      chk("mid_wait", {30'h0, st3}, 32'h2);
      rst3 = 1'b0;
      tick();
      chk("mid_state", {30'h0, st3}, 32'h0);
      chk("mid_busy", {31'h0, busy3}, 32'h0);
      chk("mid_rv", {31'h0, h3.resp_valid}, 32'h0);
      chk("mid_rdata", h3.resp_data, 32'h0);
      chk("mid_rwrite", {31'h0, h3.resp_write}, 32'h0);
      chk("mid_addr", {24'h0, addr3}, 32'h0);
      chk("mid_data", wdata3, 32'h0);
      chk("mid_rd", {31'h0, rd3}, 32'h0);
      rst3 = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("drop_rv", {31'h0, h3.resp_valid}, 32'h0);
         chk("drop_rd", {31'h0, rd3}, 32'h0);
         chk("drop_ready", {31'h0, h3.req_ready}, 32'h1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
